// File: rtl/batch_sample_scheduler.sv
// batch_sample_scheduler
// Buffers control-signal samples in a four-segment circular store and replays
// them as three streams: lookahead (reversed), backward compute (reversed) and
// forward compute (forward order). Each stream is aligned with segment
// strobes, a forward index and a warm-up-qualified valid flag.
module batch_sample_scheduler #(
   parameter int N = 3,
   parameter int DEPTH = 32,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  in,
   input  logic          in_valid,
   output logic [N-1:0]  lh_sample,
   output logic [N-1:0]  cb_sample,
   output logic [N-1:0]  cf_sample,
   output logic [AW-1:0] out_idx,
   output logic          seg_first,
   output logic          seg_last,
   output logic          out_valid
);

   localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

   // Sample store: four segments of DEPTH words, intentionally not reset
   logic [N-1:0] mem_q [4][DEPTH];

   logic [1:0]    segW_q, segW_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [1:0]    segDone_q, segDone_d;

   logic [N-1:0]  lhSample_q, cbSample_q, cfSample_q;
   logic [AW-1:0] outIdx_q;
   logic          segFirst_q, segLast_q, outValid_q;

   logic          idxLast;
   logic [AW-1:0] revIdx;
   logic [1:0]    lhSeg, cbSeg;

   // Next-state counters and read addresses, all derived from the pre-update write position
   always_comb begin
      idxLast   = (idx_q == LastIdx);
      idx_d     = idxLast ? '0 : idx_q + AW'(1);
      segW_d    = idxLast ? segW_q + 2'd1 : segW_q;
      segDone_d = (idxLast && segDone_q != 2'd3) ? segDone_q + 2'd1 : segDone_q;
      revIdx    = LastIdx - idx_q;
      lhSeg     = segW_q - 2'd1;
      cbSeg     = segW_q - 2'd2;
   end

   // Write the accepted sample; segment seg_w is never read, so writes cannot collide with reads
   always_ff @(posedge clk) begin
      if (!rst && in_valid) begin
         mem_q[segW_q][idx_q] <= in;
      end
   end

   // Counters and registered stream outputs; a stall only drops out_valid and holds everything else
   always_ff @(posedge clk) begin
      if (rst) begin
         segW_q     <= '0;
         idx_q      <= '0;
         segDone_q  <= '0;
         lhSample_q <= '0;
         cbSample_q <= '0;
         cfSample_q <= '0;
         outIdx_q   <= '0;
         segFirst_q <= 1'b0;
         segLast_q  <= 1'b0;
         outValid_q <= 1'b0;
      end else if (in_valid) begin
         segW_q     <= segW_d;
         idx_q      <= idx_d;
         segDone_q  <= segDone_d;
         lhSample_q <= mem_q[lhSeg][revIdx];
         cbSample_q <= mem_q[cbSeg][revIdx];
         cfSample_q <= mem_q[cbSeg][idx_q];
         outIdx_q   <= idx_q;
         segFirst_q <= (idx_q == '0);
         segLast_q  <= idxLast;
         outValid_q <= (segDone_q >= 2'd2);
      end else begin
         outValid_q <= 1'b0;
      end
   end

   assign lh_sample = lhSample_q;
   assign cb_sample = cbSample_q;
   assign cf_sample = cfSample_q;
   assign out_idx   = outIdx_q;
   assign seg_first = segFirst_q;
   assign seg_last  = segLast_q;
   assign out_valid = outValid_q;

endmodule

// File: tb/tb_batch_sample_scheduler.sv
// Testbench for batch_sample_scheduler: a DEPTH=4 and a DEPTH=3 instance are
// driven against a behavioural model whose expected outputs go through a
// scoreboard queue and are compared one cycle later.
module tb_batch_sample_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] in4 = '0, in3 = '0;
   logic       inValid4 = 1'b0, inValid3 = 1'b0;

   logic [2:0] lh4, cb4, cf4, lh3, cb3, cf3;
   logic [1:0] idx4, idx3;
   logic       first4, last4, valid4, first3, last3, valid3;

   int compareCount = 0;
   int failCount = 0;

   typedef struct packed {
      logic [2:0] lh;
      logic [2:0] cb;
      logic [2:0] cf;
      logic [1:0] idx;
      logic       first;
      logic       last;
      logic       valid;
   } outT;

   outT sbQ[$];
   outT mOut;
   outT lastObs;

   // Behavioural model of the scheduler
   logic [2:0] mMem [4][32];
   int mSegW, mIdx, mSegDone, mDepth;
   bit sel3;
   int accepted;

   batch_sample_scheduler #(.N(3), .DEPTH(4)) dut4 (
      .clk(clk), .rst(rst), .in(in4), .in_valid(inValid4),
      .lh_sample(lh4), .cb_sample(cb4), .cf_sample(cf4),
      .out_idx(idx4), .seg_first(first4), .seg_last(last4), .out_valid(valid4)
   );

   batch_sample_scheduler #(.N(3), .DEPTH(3)) dut3 (
      .clk(clk), .rst(rst), .in(in3), .in_valid(inValid3),
      .lh_sample(lh3), .cb_sample(cb3), .cf_sample(cf3),
      .out_idx(idx3), .seg_first(first3), .seg_last(last3), .out_valid(valid3)
   );

   // Free-running clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compareCount++;
      if (obs !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Drive one cycle, push the model's expectation, then compare after the edge
   task automatic applyStimulus(input bit r, input bit v, input logic [2:0] d);
      outT e;
      outT o;
      rst = r;
      if (sel3) begin
         inValid3 = v; in3 = d; inValid4 = 1'b0;
      end else begin
         inValid4 = v; in4 = d; inValid3 = 1'b0;
      end
      if (r) begin
         e = '0;
         mSegW = 0; mIdx = 0; mSegDone = 0;
      end else if (v) begin
         e.lh    = mMem[(mSegW + 3) % 4][mDepth - 1 - mIdx];
         e.cb    = mMem[(mSegW + 2) % 4][mDepth - 1 - mIdx];
         e.cf    = mMem[(mSegW + 2) % 4][mIdx];
         e.idx   = 2'(mIdx);
         e.first = (mIdx == 0);
         e.last  = (mIdx == mDepth - 1);
         e.valid = (mSegDone >= 2);
         mMem[mSegW][mIdx] = d;
         accepted++;
         if (mIdx == mDepth - 1) begin
            mIdx = 0;
            mSegW = (mSegW + 1) % 4;
            if (mSegDone < 3) mSegDone++;
         end else begin
            mIdx++;
         end
      end else begin
         e = mOut;
         e.valid = 1'b0;
      end
      mOut = e;
      sbQ.push_back(e);
      @(posedge clk);
      #1;
      if (sel3) o = '{lh3, cb3, cf3, idx3, first3, last3, valid3};
      else      o = '{lh4, cb4, cf4, idx4, first4, last4, valid4};
      lastObs = o;
      if (sbQ.size() == 0) begin
         checkOutput("scoreboardEmpty", 32'd1, 32'd0);
      end else begin
         e = sbQ.pop_front();
         checkOutput("outIdx", 32'(o.idx), 32'(e.idx));
         checkOutput("segFirst", 32'(o.first), 32'(e.first));
         checkOutput("segLast", 32'(o.last), 32'(e.last));
         checkOutput("outValid", 32'(o.valid), 32'(e.valid));
         if (e.valid || r) begin
            checkOutput("lhSample", 32'(o.lh), 32'(e.lh));
            checkOutput("cbSample", 32'(o.cb), 32'(e.cb));
            checkOutput("cfSample", 32'(o.cf), 32'(e.cf));
         end
      end
   endtask

   initial begin
      int validSeen;
      int cycles;
      foreach (mMem[s, i]) mMem[s][i] = '0;
      mOut = '0;
      accepted = 0;

      // Warm-up, stream ordering and a mid-segment stall on DEPTH=4
      sel3 = 1'b0; mDepth = 4;
      applyStimulus(1'b1, 1'b0, 3'd0);
      for (int k = 0; k < 20; k++) begin
         if (k == 14) begin
            repeat (5) applyStimulus(1'b0, 1'b0, 3'd0);
            checkOutput("stallValid", 32'(lastObs.valid), 32'd0);
            checkOutput("stallIdxHeld", 32'(lastObs.idx), 32'd1);
         end
         applyStimulus(1'b0, 1'b1, 3'(k));
         if (k == 7) checkOutput("warmupLow", 32'(lastObs.valid), 32'd0);
         if (k == 8) begin
            checkOutput("firstValid", 32'(lastObs.valid), 32'd1);
            checkOutput("firstSegFirst", 32'(lastObs.first), 32'd1);
            checkOutput("firstLh", 32'(lastObs.lh), 32'd7);
            checkOutput("firstCb", 32'(lastObs.cb), 32'd3);
            checkOutput("firstCf", 32'(lastObs.cf), 32'd0);
         end
         if (k == 10) checkOutput("notLast", 32'(lastObs.last), 32'd0);
         if (k == 11) begin
            checkOutput("segLast11", 32'(lastObs.last), 32'd1);
            checkOutput("cf11", 32'(lastObs.cf), 32'd3);
            checkOutput("lh11", 32'(lastObs.lh), 32'd4);
         end
         if (k == 12) begin
            checkOutput("cf12", 32'(lastObs.cf), 32'd4);
            checkOutput("cb12", 32'(lastObs.cb), 32'd7);
            checkOutput("lh12", 32'(lastObs.lh), 32'd3);
         end
         if (k == 14) begin
            checkOutput("resumeIdx", 32'(lastObs.idx), 32'd2);
            checkOutput("resumeValid", 32'(lastObs.valid), 32'd1);
            checkOutput("resumeCf", 32'(lastObs.cf), 32'd6);
         end
      end

      // Mid-segment reset with a simultaneous valid sample
      applyStimulus(1'b1, 1'b0, 3'd0);
      for (int k = 0; k < 14; k++) applyStimulus(1'b0, 1'b1, 3'(k + 2));
      applyStimulus(1'b1, 1'b1, 3'd5);
      checkOutput("rstValid", 32'(lastObs.valid), 32'd0);
      checkOutput("rstLh", 32'(lastObs.lh), 32'd0);
      validSeen = 0;
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1'b0, 1'b1, 3'(k + 1));
         if (lastObs.valid) validSeen++;
      end
      checkOutput("rstWarmup", 32'(validSeen), 32'd0);
      applyStimulus(1'b0, 1'b1, 3'd0);
      checkOutput("rstWarmupEnd", 32'(lastObs.valid), 32'd1);

      // Non-power-of-two DEPTH=3
      sel3 = 1'b1; mDepth = 3;
      applyStimulus(1'b1, 1'b0, 3'd0);
      for (int k = 0; k < 12; k++) begin
         applyStimulus(1'b0, 1'b1, 3'(k));
         checkOutput("d3Idx", 32'(lastObs.idx), 32'(k % 3));
         checkOutput("d3Valid", 32'(lastObs.valid), 32'(k >= 6));
      end

      // Long random run on DEPTH=4: 40 segments with 50% valid
      sel3 = 1'b0; mDepth = 4;
      applyStimulus(1'b1, 1'b0, 3'd0);
      accepted = 0;
      cycles = 0;
      while (accepted < 160 && cycles < 2000) begin
         applyStimulus(1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
         cycles++;
      end
      checkOutput("randomRunDone", 32'(accepted >= 160), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
